// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, types, FSM encoding, GF(2^8) helpers,
// round-level transforms and the FIPS-197 reference vectors.
package aes_pkg;

  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Entry n lives at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam state_t FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam state_t FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam state_t FIPS_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t FIPS_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam state_t FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic byte_t sbox(input byte_t b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_LUT[idx -: 8];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // 0x80 wraps to 0x1b through the xtime reduction.
  function automatic byte_t rcon_next(input byte_t rc);
    return xtime(rc);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t t;
    for (int i = 0; i < 4; i++) begin
      t[127-32*i -: 32] = sub_word(s[127-32*i -: 32]);
    end
    return t;
  endfunction

  // Byte n holds row n%4 of column n/4; row r rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return t;
  endfunction

  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction

  function automatic state_t key_step(input state_t k, input byte_t rc);
    word_t w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 round: derives the next round key from the
// previous one and applies it to the state.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic [7:0]   i_rcon,
  input  logic         i_last,
  output logic [127:0] o_state,
  output logic [127:0] o_rkey,
  output logic [7:0]   o_rcon
);

  logic [127:0] w_key_next;
  logic [127:0] w_shifted;
  logic [127:0] w_mixed;

  assign w_key_next = key_step(i_rkey, i_rcon);
  assign w_shifted  = shift_rows(sub_bytes(i_state));

  // Final round skips MixColumns.
  always_comb begin
    w_mixed = w_shifted;
    if (!i_last) begin
      for (int c = 0; c < 4; c++) begin
        w_mixed[127-32*c -: 32] = mix_column(w_shifted[127-32*c -: 32]);
      end
    end else begin
      w_mixed = w_shifted;
    end
  end

  assign o_state = w_mixed ^ w_key_next;
  assign o_rkey  = w_key_next;
  assign o_rcon  = rcon_next(i_rcon);

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE chained rounds per clock,
// on-the-fly key expansion, valid/ready on both sides.
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit ZERO_OUT_IDLE    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_ITER = NR / ROUNDS_PER_CYCLE;
  localparam logic [3:0] ITER_LAST = 4'(NUM_ITER - 1);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_encrypt_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  fsm_state_e   r_fsm;
  fsm_state_e   w_fsm_next;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [7:0]   r_rcon;
  logic [3:0]   r_iter;
  logic [127:0] r_out_data;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         r_busy;
  logic         w_accept;
  logic         w_finish;
  logic         w_release;
  logic         w_iter_last;

  logic [127:0] w_chain_state [ROUNDS_PER_CYCLE+1];
  logic [127:0] w_chain_key   [ROUNDS_PER_CYCLE+1];
  logic [7:0]   w_chain_rcon  [ROUNDS_PER_CYCLE+1];
  logic [ROUNDS_PER_CYCLE-1:0] w_last;

  assign w_iter_last      = (r_iter == ITER_LAST);
  assign w_chain_state[0] = r_state;
  assign w_chain_key[0]   = r_rkey;
  assign w_chain_rcon[0]  = r_rcon;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    // Only the tail copy on the final iteration computes round 10.
    if (g == ROUNDS_PER_CYCLE - 1) begin : g_tail
      assign w_last[g] = w_iter_last;
    end else begin : g_mid
      assign w_last[g] = 1'b0;
    end

    aes_round_step u_step (
      .i_state (w_chain_state[g]),
      .i_rkey  (w_chain_key[g]),
      .i_rcon  (w_chain_rcon[g]),
      .i_last  (w_last[g]),
      .o_state (w_chain_state[g+1]),
      .o_rkey  (w_chain_key[g+1]),
      .o_rcon  (w_chain_rcon[g+1])
    );
  end

  // Next-state and handshake decode.
  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    w_release  = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept   = 1'b1;
          w_fsm_next = ST_RUN;
        end else begin
          w_fsm_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_iter_last) begin
          w_finish   = 1'b1;
          w_fsm_next = ST_DONE;
        end else begin
          w_fsm_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_release  = 1'b1;
          w_fsm_next = ST_IDLE;
        end else begin
          w_fsm_next = ST_DONE;
        end
      end
      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_in_ready <= (w_fsm_next == ST_IDLE);
      r_busy     <= (w_fsm_next != ST_IDLE);
    end
  end

  // Round datapath: load on accept, advance while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rkey  <= '0;
      r_rcon  <= 8'h00;
      r_iter  <= 4'd0;
    end else if (w_accept) begin
      r_state <= in_data ^ in_key;
      r_rkey  <= in_key;
      r_rcon  <= 8'h01;
      r_iter  <= 4'd0;
    end else if (r_fsm == ST_RUN) begin
      r_state <= w_chain_state[ROUNDS_PER_CYCLE];
      r_rkey  <= w_chain_key[ROUNDS_PER_CYCLE];
      r_rcon  <= w_chain_rcon[ROUNDS_PER_CYCLE];
      r_iter  <= r_iter + 4'd1;
    end else begin
      r_state <= r_state;
      r_rkey  <= r_rkey;
      r_rcon  <= r_rcon;
      r_iter  <= r_iter;
    end
  end

  // Output register, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_finish) begin
      r_out_data  <= w_chain_state[ROUNDS_PER_CYCLE];
      r_out_valid <= 1'b1;
    end else if (w_release) begin
      r_out_data  <= r_out_data;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= r_out_data;
      r_out_valid <= r_out_valid;
    end
  end

  if (ZERO_OUT_IDLE) begin : g_zero_idle
    assign out_data = r_out_valid ? r_out_data : 128'h0;
  end else begin : g_hold_idle
    assign out_data = r_out_data;
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed + random bench for aes128_encrypt_iter against an array-based
// AES-128 model with a full 44-word key schedule and a computed S-box.
module tb_aes128_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         x_in_valid;
  logic         x_out_ready;
  logic [2:0]   x_in_ready;
  logic [2:0]   x_out_valid;
  logic [2:0]   x_busy;
  logic [127:0] x_out_data [3];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [256];

  aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(1), .ZERO_OUT_IDLE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(2), .ZERO_OUT_IDLE(1'b0)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready[0]),
    .in_data(in_data), .in_key(in_key), .out_valid(x_out_valid[0]),
    .out_ready(x_out_ready), .out_data(x_out_data[0]), .busy(x_busy[0]));

  aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(5), .ZERO_OUT_IDLE(1'b1)) u_r5 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready[1]),
    .in_data(in_data), .in_key(in_key), .out_valid(x_out_valid[1]),
    .out_ready(x_out_ready), .out_data(x_out_data[1]), .busy(x_busy[1]));

  aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(10), .ZERO_OUT_IDLE(1'b1)) u_r10 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready[2]),
    .in_data(in_data), .in_key(in_key), .out_valid(x_out_valid[2]),
    .out_ready(x_out_ready), .out_data(x_out_data[2]), .busy(x_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        inv = x;
        for (int k = 0; k < 253; k++) inv = gm(inv, x);
      end
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk_int("ready_before_send", int'(in_ready), 1);
    in_data = pt; in_key = key; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_int("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic run_x(input logic [127:0] pt, input logic [127:0] key);
    int lat [3];
    int exp_lat [3];
    logic [127:0] exp;
    exp = aes_ref(pt, key);
    exp_lat[0] = 5; exp_lat[1] = 2; exp_lat[2] = 1;
    for (int k = 0; k < 3; k++) lat[k] = -1;
    in_data = pt; in_key = key; x_in_valid = 1'b1;
    tick();
    x_in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int k = 0; k < 3; k++)
        if (x_out_valid[k] && lat[k] < 0) lat[k] = c;
    end
    for (int k = 0; k < 3; k++) begin
      chk_int($sformatf("x%0d_latency", k), lat[k], exp_lat[k]);
      chk($sformatf("x%0d_data", k), x_out_data[k], exp);
    end
    x_out_ready = 1'b1;
    tick();
    x_out_ready = 1'b0;
    chk_int("x_valid_dropped", int'(x_out_valid), 0);
    chk("x0_hold_after_release", x_out_data[0], exp);
    chk("x1_zero_after_release", x_out_data[1], 128'h0);
    chk("x2_zero_after_release", x_out_data[2], 128'h0);
  endtask

  initial begin
    int lat;
    int d;
    logic [127:0] pt, key, held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in_valid = 1'b0; x_out_ready = 1'b0;
    in_data = '0; in_key = '0;
    build_sbox();
    tick(); tick();
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    tick();

    // FIPS C.1 with exact latency, then 20 cycles of backpressure.
    send(C1_PT, C1_KEY);
    wait_out(lat);
    chk_int("c1_latency", lat, 10);
    chk("c1_data", out_data, C1_CT);
    chk("c1_model", out_data, aes_ref(C1_PT, C1_KEY));
    held = out_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_int("bp_valid", int'(out_valid), 1);
      chk("bp_data", out_data, held);
      chk_int("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("release_valid", int'(out_valid), 0);
    chk_int("release_in_ready", int'(in_ready), 1);
    chk_int("release_busy", int'(busy), 0);
    chk("release_zero_data", out_data, 128'h0);

    // Offer another block while busy: must be ignored.
    send(C1_PT, C1_KEY);
    tick(); tick(); tick();
    in_data = B_PT; in_key = B_KEY; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("busy_ignore_data", out_data, C1_CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_int("no_second_valid", int'(out_valid), 0);
    end

    // Reset at iteration 5 discards the block.
    send(C1_PT, C1_KEY);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", out_data, 128'h0);
    chk_int("midrst_in_ready", int'(in_ready), 1);
    chk_int("midrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_int("postrst_valid", int'(out_valid), 0);
    send(C1_PT, C1_KEY);
    wait_out(lat);
    chk_int("postrst_latency", lat, 10);
    chk("postrst_data", out_data, C1_CT);
    out_ready = 1'b1;
    tick();

    // Back-to-back with out_ready tied high.
    in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    tick();
    in_data = B_PT; in_key = B_KEY;
    wait_out(lat);
    chk_int("b2b_first_latency", lat, 10);
    chk("b2b_first_data", out_data, C1_CT);
    tick();
    chk_int("b2b_handshake_ready", int'(in_ready), 1);
    chk_int("b2b_handshake_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk_int("b2b_second_accept", int'(busy), 1);
    wait_out(lat);
    chk_int("b2b_second_latency", lat, 10);
    chk("b2b_second_data", out_data, B_CT);
    tick();
    out_ready = 1'b0;

    // Random blocks with random consumer delay.
    for (int n = 0; n < 6; n++) begin
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, key);
      wait_out(lat);
      chk_int("rand_latency", lat, 10);
      chk("rand_data", out_data, aes_ref(pt, key));
      d = int'($urandom_range(3, 0));
      for (int i = 0; i < d; i++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_int("rand_release", int'(out_valid), 0);
    end

    // Unrolled variants R=2,5,10.
    run_x(B_PT, B_KEY);
    for (int n = 0; n < 2; n++) begin
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_x(pt, key);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
